// File: rtl/delay_chain_meas_ctrl_pkg.sv
// rtl/delay_chain_meas_ctrl_pkg.sv - shared types, default widths and saturating add for the delay measurement block
package delay_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REST,
        ST_CHECK,
        ST_LAUNCH,
        ST_MEASURE,
        ST_FINISH
    } meas_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TRIAL_W     = 8;
    localparam int DEF_SUM_W       = 24;
    localparam int DEF_SETTLE_CYC  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Adds two values and clamps the result to the all-ones value of a width-bit field.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] s;
        logic [63:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/delay_chain_meas_ctrl_if.sv
// rtl/delay_chain_meas_ctrl_if.sv - host-side control/result bundle (option: DELAY_MINMAX_EN)
interface delay_chain_meas_ctrl_if #(
    parameter int CNT_W   = delay_meas_pkg::DEF_CNT_W,
    parameter int TRIAL_W = delay_meas_pkg::DEF_TRIAL_W,
    parameter int SUM_W   = delay_meas_pkg::DEF_SUM_W
);
    logic               start;
    logic [TRIAL_W-1:0] trials;
    logic [CNT_W-1:0]   timeout;
    logic               busy;
    logic               done;
    logic               error;
    logic [SUM_W-1:0]   delay_sum;
    logic [CNT_W-1:0]   last_delay;
    logic [TRIAL_W-1:0] trials_done;
`ifdef DELAY_MINMAX_EN
    logic [CNT_W-1:0]   delay_min;
    logic [CNT_W-1:0]   delay_max;
`endif

    modport master (
        output start, trials, timeout,
        input  busy, done, error, delay_sum, last_delay, trials_done
`ifdef DELAY_MINMAX_EN
        , input delay_min, delay_max
`endif
    );

    modport slave (
        input  start, trials, timeout,
        output busy, done, error, delay_sum, last_delay, trials_done
`ifdef DELAY_MINMAX_EN
        , output delay_min, delay_max
`endif
    );

endinterface

// File: rtl/delay_chain_meas_ctrl_sync.sv
// rtl/delay_chain_meas_ctrl_sync.sv - reset-to-0 synchroniser for the asynchronous delay path result
module delay_path_sync #(
    parameter int STAGES = delay_meas_pkg::DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/delay_chain_meas_ctrl.sv
// rtl/delay_chain_meas_ctrl.sv - delay chain measurement sequencer (option: DELAY_MINMAX_EN adds min/max)
module delay_chain_meas_ctrl
    import delay_meas_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRIAL_W      = DEF_TRIAL_W,
    parameter int SUM_W        = DEF_SUM_W,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter bit PATH_INVERTS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    delay_chain_meas_ctrl_if.slave  host,
    output logic                    path_input,
    input  logic                    path_result
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    meas_state_t        r_state;
    logic [TRIAL_W-1:0] r_trials;
    logic [CNT_W-1:0]   r_timeout;
    logic [CNT_W-1:0]   r_cnt;
    logic [SET_W-1:0]   r_settle;
    logic               r_path_input;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [SUM_W-1:0]   r_delay_sum;
    logic [CNT_W-1:0]   r_last_delay;
    logic [TRIAL_W-1:0] r_trials_done;
`ifdef DELAY_MINMAX_EN
    logic [CNT_W-1:0]   r_delay_min;
    logic [CNT_W-1:0]   r_delay_max;
`endif

    logic               w_res_s;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [TRIAL_W-1:0] w_td_inc;
    logic [SUM_W-1:0]   w_sum_next;
    logic               w_rest_lvl;
    logic               w_hi_lvl;

    delay_path_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (path_result),
        .o_q   (w_res_s)
    );

    // Expected synchronised levels for a parked (0) and launched (1) chain input.
    assign w_rest_lvl = PATH_INVERTS;
    assign w_hi_lvl   = ~PATH_INVERTS;

    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_td_inc   = r_trials_done + TRIAL_W'(1);
    assign w_sum_next = SUM_W'(sat_add(64'(r_delay_sum), 64'(w_cnt_inc), SUM_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_trials      <= '0;
            r_timeout     <= '0;
            r_cnt         <= '0;
            r_settle      <= '0;
            r_path_input  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_delay_sum   <= '0;
            r_last_delay  <= '0;
            r_trials_done <= '0;
`ifdef DELAY_MINMAX_EN
            r_delay_min   <= '0;
            r_delay_max   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (host.start) begin
                        r_trials      <= (host.trials == '0) ? TRIAL_W'(1) : host.trials;
                        r_timeout     <= host.timeout;
                        r_delay_sum   <= '0;
                        r_trials_done <= '0;
                        r_error       <= 1'b0;
                        r_busy        <= 1'b1;
                        r_settle      <= '0;
`ifdef DELAY_MINMAX_EN
                        r_delay_min   <= '1;
                        r_delay_max   <= '0;
`endif
                        r_state       <= ST_REST;
                    end
                end
                ST_REST: begin
                    r_path_input <= 1'b0;
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    // A result not at its rest level after settling means the chain is stuck.
                    if (w_res_s != w_rest_lvl) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_path_input <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_res_s == w_hi_lvl) begin
                        r_last_delay  <= w_cnt_inc;
                        r_delay_sum   <= w_sum_next;
                        r_trials_done <= w_td_inc;
                        r_path_input  <= 1'b0;
`ifdef DELAY_MINMAX_EN
                        if (w_cnt_inc < r_delay_min) r_delay_min <= w_cnt_inc;
                        if (w_cnt_inc > r_delay_max) r_delay_max <= w_cnt_inc;
`endif
                        if (w_td_inc < r_trials) begin
                            r_settle <= '0;
                            r_state  <= ST_REST;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= ST_FINISH;
                        end
                    end else if ((r_timeout != '0) && (w_cnt_inc == r_timeout)) begin
                        r_error      <= 1'b1;
                        r_path_input <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_FINISH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_FINISH: begin
                    // done is high during this state, so a start seen here is dropped.
                    r_path_input <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign path_input       = r_path_input;
    assign host.busy        = r_busy;
    assign host.done        = r_done;
    assign host.error       = r_error;
    assign host.delay_sum   = r_delay_sum;
    assign host.last_delay  = r_last_delay;
    assign host.trials_done = r_trials_done;
`ifdef DELAY_MINMAX_EN
    assign host.delay_min   = r_delay_min;
    assign host.delay_max   = r_delay_max;
`endif

endmodule

// File: tb/tb_delay_chain_meas_ctrl.sv
// tb/tb_delay_chain_meas_ctrl.sv - directed and randomized self-checking bench for delay_chain_meas_ctrl
module tb_delay_chain_meas_ctrl;
    localparam int CNT_W        = 16;
    localparam int TRIAL_W      = 8;
    localparam int SUM_W        = 8;
    localparam int SETTLE_CYC   = 16;
    localparam int SYNC_STAGES  = 2;
    localparam bit PATH_INVERTS = 1'b0;
    localparam longint SUM_MAX  = (64'd1 << SUM_W) - 1;
    localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic path_input;
    logic path_result;

    int checks = 0;
    int failures = 0;

    // Chain model: 0 = buffer of chain_d cycles, 1 = output tied low, 2 = output stuck high.
    int          chain_mode = 0;
    int          chain_d    = 1;
    logic [63:0] chain_pipe = '0;
    bit          saw_hi     = 1'b0;

    longint e_err, e_td, e_sum, e_min, e_max;
    longint m_last = 0;
    bit     seen;

    delay_chain_meas_ctrl_if #(.CNT_W(CNT_W), .TRIAL_W(TRIAL_W), .SUM_W(SUM_W)) host ();

    delay_chain_meas_ctrl #(
        .CNT_W        (CNT_W),
        .TRIAL_W      (TRIAL_W),
        .SUM_W        (SUM_W),
        .SETTLE_CYC   (SETTLE_CYC),
        .SYNC_STAGES  (SYNC_STAGES),
        .PATH_INVERTS (PATH_INVERTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host),
        .path_input  (path_input),
        .path_result (path_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chain_pipe <= {chain_pipe[62:0], path_input};
    always @(posedge clk) if (path_input) saw_hi <= 1'b1;

    assign path_result = (chain_mode == 0) ? chain_pipe[chain_d-1] : (chain_mode == 2);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outcome of a run from the chain delay, trial count and timeout alone.
    task automatic model_run(input int n, input int tmo, input int mode, input int d);
        longint eff, dly, s;
        eff = (n == 0) ? 1 : n;
        dly = d + SYNC_STAGES + 1;
        e_err = 1; e_td = 0; e_sum = 0; e_min = CNT_MAX; e_max = 0;
        if (mode == 0 && !(tmo != 0 && tmo < dly)) begin
            s      = eff * dly;
            e_err  = 0;
            e_td   = eff;
            e_sum  = (s > SUM_MAX) ? SUM_MAX : s;
            m_last = dly;
            e_min  = dly;
            e_max  = dly;
        end
    endtask

    task automatic start_run(input string tag, input int n, input int tmo, input int mode, input int d);
        chain_mode   = mode;
        chain_d      = d;
        host.trials  = TRIAL_W'(n);
        host.timeout = CNT_W'(tmo);
        model_run(n, tmo, mode, d);
        @(negedge clk);
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        chk({tag, "_busy_on_start"}, host.busy, 1);
    endtask

    task automatic wait_done(input string tag, input int extra_start_at);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == extra_start_at) host.start = 1'b1;
            if (i == extra_start_at + 3) host.start = 1'b0;
            if (host.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (extra_start_at >= 0) host.start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_error"}, host.error, e_err);
        chk({tag, "_trials_done"}, host.trials_done, e_td);
        chk({tag, "_delay_sum"}, host.delay_sum, e_sum);
        chk({tag, "_last_delay"}, host.last_delay, m_last);
        chk({tag, "_path_low"}, path_input, 0);
`ifdef DELAY_MINMAX_EN
        chk({tag, "_delay_min"}, host.delay_min, e_min);
        chk({tag, "_delay_max"}, host.delay_max, e_max);
`endif
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_done_single"}, host.done, 0);
        chk({tag, "_busy_cleared"}, host.busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, host.busy, 0);
        chk({tag, "_done"}, host.done, 0);
        chk({tag, "_error"}, host.error, 0);
        chk({tag, "_delay_sum"}, host.delay_sum, 0);
        chk({tag, "_last_delay"}, host.last_delay, 0);
        chk({tag, "_trials_done"}, host.trials_done, 0);
        chk({tag, "_path_input"}, path_input, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, n, tmo, sel, dly;
        host.start   = 1'b0;
        host.trials  = '0;
        host.timeout = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_run("buf7", 4, 0, 0, 7);
        wait_done("buf7", -1);
        check_results("buf7");
        chk("buf7_last_is_10", host.last_delay, 10);
        chk("buf7_sum_is_40", host.delay_sum, 40);
        check_idle("buf7");

        start_run("tied0", 3, 20, 1, 1);
        wait_done("tied0", -1);
        check_results("tied0");
        check_idle("tied0");

        saw_hi = 1'b0;
        start_run("stuck", 2, 0, 2, 1);
        wait_done("stuck", -1);
        check_results("stuck");
        chk("stuck_no_launch", saw_hi, 0);
        check_idle("stuck");

        start_run("trials0", 0, 0, 0, 5);
        wait_done("trials0", -1);
        check_results("trials0");
        chk("trials0_one_trial", host.trials_done, 1);
        check_idle("trials0");

        start_run("dblstart", 3, 0, 0, 7);
        wait_done("dblstart", 20);
        check_results("dblstart");
        check_idle("dblstart");

        start_run("tmo_eq", 2, 10, 0, 7);
        wait_done("tmo_eq", -1);
        check_results("tmo_eq");
        check_idle("tmo_eq");

        start_run("tmo_lt", 2, 9, 0, 7);
        wait_done("tmo_lt", -1);
        check_results("tmo_lt");
        check_idle("tmo_lt");

        start_run("sat", 30, 0, 0, 12);
        wait_done("sat", -1);
        check_results("sat");
        check_idle("sat");

        start_run("at_done", 2, 0, 0, 4);
        wait_done("at_done", -1);
        check_results("at_done");
        host.start = 1'b1;
        @(negedge clk);
        chk("start_at_done_ignored", host.busy, 0);
        @(negedge clk);
        host.start = 1'b0;
        chk("start_after_done_accepted", host.busy, 1);
        model_run(2, 0, 0, 4);
        wait_done("at_done2", -1);
        check_results("at_done2");
        check_idle("at_done2");

        for (int k = 0; k < 8; k++) begin
            d   = $urandom_range(1, 12);
            n   = $urandom_range(0, 6);
            dly = d + SYNC_STAGES + 1;
            sel = $urandom_range(0, 2);
            if (sel == 0)      tmo = 0;
            else if (sel == 1) tmo = $urandom_range(dly, 40);
            else               tmo = $urandom_range(1, dly - 1);
            start_run($sformatf("rnd%0d", k), n, tmo, 0, d);
            wait_done($sformatf("rnd%0d", k), -1);
            check_results($sformatf("rnd%0d", k));
            check_idle($sformatf("rnd%0d", k));
        end

        start_run("rst_mid", 5, 0, 0, 7);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (host.trials_done == TRIAL_W'(1) && path_input === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_trial2", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        m_last = 0;
        check_all_zero("rst_mid");
        repeat (30) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run("post_rst", 2, 0, 0, 7);
        wait_done("post_rst", -1);
        check_results("post_rst");
        check_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
